// File: rtl/datapath_pkg.sv
// Shared datapath types for the 2602 register file.
// Every bus-facing register uses word_t.
package datapath_pkg;
  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/a_reg_if.sv
// Bus-side bundle of register A.
// Master drives bus/load; slave returns A.
interface a_reg_if;
  import datapath_pkg::*;
  word_t bus;
  logic  a_in;
  word_t A;

  modport master (
    output bus,
    output a_in,
    input  A
  );

  modport slave (
    input  bus,
    input  a_in,
    output A
  );
endinterface

// File: rtl/load_reg.sv
// Generic register with synchronous clear and load enable.
// Clear beats load; otherwise the value is held.
module load_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (rst)     q_d = '0;
    else if (ld) q_d = d;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/a_reg.sv
// Accumulator/operand register A of the 2602 datapath.
// Captures the shared bus on a_in; A is a pure flop output.
module a_reg
  import datapath_pkg::*;
(
  input logic  clk,
  input logic  rst,
  a_reg_if.slave io
);
  load_reg #(
    .WIDTH (DATA_W)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .ld  (io.a_in),
    .d   (io.bus),
    .q   (io.A)
  );
endmodule

// File: tb/tb_a_reg.sv
// Self-checking bench for a_reg: directed steps then random traffic.
// Reference: A tracks the last bus value captured under load, zero after reset.
module tb_a_reg;
  import datapath_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  word_t model_a;

  a_reg_if io ();

  a_reg dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t exp);
    checks++;
    assert (io.A === exp) else begin
      errors++;
      $error("FAIL %s: A=%h expected=%h", tag, io.A, exp);
    end
  endtask

  // Drive at the falling edge, update model at the rising edge, check 1ns later.
  task automatic step(input string tag, input logic r,
                      input logic l, input word_t b);
    @(negedge clk);
    rst     = r;
    io.a_in = l;
    io.bus  = b;
    @(posedge clk);
    if (r)      model_a = '0;
    else if (l) model_a = b;
    #1;
    check(tag, model_a);
  endtask

  initial begin
    rst     = 1'b0;
    io.a_in = 1'b0;
    io.bus  = '0;
    model_a = '0;

    step("reset", 1'b1, 1'b0, 16'h0000);
    step("post_reset_hold", 1'b0, 1'b0, 16'h0000);
    step("load_5", 1'b0, 1'b1, 16'h0005);
    step("hold_a", 1'b0, 1'b0, 16'h0002);
    step("hold_b", 1'b0, 1'b0, 16'h0002);
    step("hold_c", 1'b0, 1'b0, 16'h0002);
    step("reset_after_load", 1'b1, 1'b0, 16'h0002);
    step("stay_zero", 1'b0, 1'b0, 16'h0002);
    step("load_7", 1'b0, 1'b1, 16'h0007);
    step("rst_beats_load", 1'b1, 1'b1, 16'hFFFF);
    step("b2b_1234", 1'b0, 1'b1, 16'h1234);
    step("b2b_abcd", 1'b0, 1'b1, 16'hABCD);

    // Bus glitches between edges must not reach A.
    @(negedge clk);
    io.a_in = 1'b0;
    io.bus  = 16'h5A5A;
    #1 check("mid_cycle_bus_glitch", 16'hABCD);
    io.a_in = 1'b1;
    io.bus  = 16'hFFFF;
    #1 check("mid_cycle_load_no_comb_path", 16'hABCD);
    io.a_in = 1'b0;
    @(posedge clk);
    #1 check("glitch_edge_hold", 16'hABCD);
    model_a = 16'hABCD;

    step("load_ffff", 1'b0, 1'b1, 16'hFFFF);
    step("load_0000", 1'b0, 1'b1, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      step("random",
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1),
           word_t'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
